present80_enc_core: RTL

//   Iterative PRESENT-80 block-cipher encryption core: 64-bit block, 80-bit key, one round per clock.

---
 rtl/present80_enc_core.sv | 132 +++++++++++++
 1 files changed

// File: rtl/present80_enc_core.sv
// Iterative PRESENT-80 encryption core: one round per clock, valid/ready on both sides.
// Key register k holds the 80-bit schedule state; the round key is always k[79:16].
module present80_enc_core #(
  parameter int unsigned ROUNDS        = 31,
  parameter bit          CLEAR_ON_DONE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] plaintext,
  input  logic [79:0] key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] ciphertext,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StRound, StFinal, StDone} state_e;

  // Nibble x of the table is S(x).
  localparam logic [63:0] SboxTable = 64'h21748FE3DA09B65C;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SboxTable[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [63:0] sbox_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 16; i++) begin
      y[4*i +: 4] = sbox(x[4*i +: 4]);
    end
    return y;
  endfunction

  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] y;
    logic [5:0]  j;
    y = '0;
    for (int i = 0; i < 63; i++) begin
      j    = 6'((16 * i) % 63);
      y[j] = x[i];
    end
    y[63] = x[63];
    return y;
  endfunction

  state_e      state_q, state_d;
  logic [63:0] st_q, st_d;
  logic [79:0] k_q, k_d;
  logic [63:0] ct_q, ct_d;
  logic [4:0]  ctr_q, ctr_d;
  logic        ov_q, ov_d;
  logic        armed_q;
  logic [79:0] k_rot;

  // armed_q keeps in_ready low until the first edge after reset release.
  assign in_ready   = (state_q == StIdle) & armed_q;
  assign out_valid  = ov_q;
  assign ciphertext = ct_q;
  assign busy       = (state_q == StRound) | (state_q == StFinal);

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    k_d     = k_q;
    ct_d    = ct_q;
    ctr_d   = ctr_q;
    ov_d    = ov_q;
    k_rot   = {k_q[18:0], k_q[79:19]};
    unique case (state_q)
      StIdle: begin
        ctr_d = '0;
        if (in_valid && in_ready) begin
          st_d    = plaintext;
          k_d     = key;
          ctr_d   = 5'd1;
          state_d = StRound;
        end
      end
      StRound: begin
        st_d          = p_layer(sbox_layer(st_q ^ k_q[79:16]));
        k_rot[79:76]  = sbox(k_rot[79:76]);
        k_rot[19:15]  = k_rot[19:15] ^ ctr_q;
        k_d           = k_rot;
        ctr_d         = ctr_q + 5'd1;
        if (ctr_q == 5'(ROUNDS)) begin
          state_d = StFinal;
        end
      end
      StFinal: begin
        ct_d    = st_q ^ k_q[79:16];
        ov_d    = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = StIdle;
          if (CLEAR_ON_DONE) begin
            st_d = '0;
            k_d  = '0;
            ct_d = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      st_q    <= '0;
      k_q     <= '0;
      ct_q    <= '0;
      ctr_q   <= '0;
      ov_q    <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      k_q     <= k_d;
      ct_q    <= ct_d;
      ctr_q   <= ctr_d;
      ov_q    <= ov_d;
      armed_q <= 1'b1;
    end
  end

endmodule
